lut_mult_pipe: RTL and testbench
================================

// Module: lut_mult_pipe
// PURPOSE
//   Pipelined LUT multiplier with a runtime-loadable coefficient; successor to the fixed-constant LUT multiplier.
//   C = X * A, where A is loaded at run time through a build state machine and X streams through valid/ready.
//   A nibble-product table (A*k, k=0..2^DIGIT_W-1) is built sequentially, then X digits index it in parallel.
//   Sits in the datapath as a drop-in streaming constant-coefficient multiplier (filters, scalers).
// PARAMETERS
//   BIT_WIDTH  8  width of multiplicand X; must be a multiple of DIGIT_W
//   A_WIDTH    8  width of coefficient A
//   DIGIT_W    4  LUT index width; table depth = 2^DIGIT_W, NDIG = BIT_WIDTH/DIGIT_W digits
// PORTS
//   clk        in   1                  single clock, all logic on rising edge
//   rst        in   1                  synchronous, active-high reset
//   coef_load  in   1                  request to load new coefficient (sampled when load_ready=1)
//   coef_in    in   A_WIDTH            coefficient value captured on accepted coef_load
//   load_ready out  1                  coefficient load may be accepted this cycle
//   in_valid   in   1                  X valid
//   in_ready   out  1                  block accepts X this cycle
//   X          in   BIT_WIDTH          multiplicand
//   out_valid  out  1                  C valid
//   out_ready  in   1                  downstream accepts C
//   C          out  BIT_WIDTH+A_WIDTH  product X*A, unsigned, full width, no truncation
// BEHAVIOUR
//   Reset: state=IDLE, load_ready=1, in_ready=0, out_valid=0, C=0, stage-1 valid=0, table cleared to 0.
//   FSM IDLE -> BUILD on accepted coef_load; BUILD -> READY after table complete; READY -> BUILD on accepted coef_load.
//   load_ready = (state!=BUILD) && stage-1 empty && !out_valid (pipeline drained); coef_load ignored otherwise.
//   BUILD: cycle of acceptance captures A=coef_in, entry[0]=0, k=1; each following cycle entry[k]=entry[k-1]+A, k++;
//     after entry[2^DIGIT_W-1] written, state=READY; build lasts exactly 2^DIGIT_W-1 cycles after acceptance.
//   in_ready = (state==READY) && !coef_load && !stall; stall = out_valid && !out_ready.
//   Accepted coef_load and in_valid in same cycle: load wins (in_ready=0 that cycle, X not consumed).
//   Pipeline (advances only when !stall; full stall holds all stage registers and C):
//     stage 1: pp[i] = entry[X[i*DIGIT_W +: DIGIT_W]], i=0..NDIG-1, registered with valid.
//     stage 2: C = sum_i (pp[i] << (i*DIGIT_W)), registered, out_valid set.
//   Latency: X accepted at edge t -> out_valid=1 with C at edge t+2; throughput 1 per cycle when out_ready=1.
//   out_valid && !out_ready: C and out_valid held stable until handshake; no data lost or duplicated.
//   Table entries A_WIDTH+DIGIT_W wide; stage-2 sum in BIT_WIDTH+A_WIDTH bits, cannot overflow.
//   A=0: table all zero, C=0 for every X. X=0: C=0.
//   Reset mid-BUILD or mid-stream: everything returns to reset state next edge; in-flight results discarded;
//     a new coef_load is required before any X is accepted.
//   No X is ever accepted in IDLE (no coefficient loaded yet).
// TESTING
//   Reset, load A=2, wait READY, stream X=0..255 back-to-back, out_ready=1 -> C=2*X each, out_valid 2 cycles after accept, no gaps.
//   Load A=255, X=255 -> C=65025; X=1 -> 255; load A=0, X=200 -> C=0; build takes 15 cycles, in_ready=0 throughout.
//   Backpressure: A=7, stream X=10,11,12 with out_ready low 5 cycles after first out_valid -> C=70 held, then 77,84 in order.
//   coef_load while result pending (out_valid=1, out_ready=0) -> load_ready=0, load ignored, A unchanged, C=X*old A.
//   coef_load and in_valid same cycle in READY, empty pipe -> load accepted, X not consumed (in_ready=0), later X uses new A.
//   Assert rst at BUILD cycle 6 -> state IDLE, in_ready=0, out_valid=0; next load A=3, X=100 -> C=300.

Source files
------------

// File: rtl/lut_mult_pipe.sv
// Streaming X*A multiplier. The coefficient A is loaded at run time into a table of A*k values, one entry per cycle.
// X digits index that table in stage 1; stage 2 adds the shifted partial products. A stall holds both stages.
module lut_mult_pipe #(
  parameter int BIT_WIDTH = 8,
  parameter int A_WIDTH   = 8,
  parameter int DIGIT_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         coef_load,
  input  logic [A_WIDTH-1:0]           coef_in,
  output logic                         load_ready,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIT_WIDTH-1:0]         X,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BIT_WIDTH+A_WIDTH-1:0] C
);
  localparam int NDIG  = BIT_WIDTH / DIGIT_W;
  localparam int DEPTH = 1 << DIGIT_W;
  localparam int TW    = A_WIDTH + DIGIT_W;
  localparam int CW    = BIT_WIDTH + A_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_READY} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [A_WIDTH-1:0] r_a;
  logic [DIGIT_W-1:0] r_k;
  logic [TW-1:0]      r_table [DEPTH];
  logic               r_s1_vld;
  logic [TW-1:0]      r_pp [NDIG];
  logic               r_out_vld;
  logic [CW-1:0]      r_c;
  logic               w_stall;
  logic               w_load_acc;
  logic               w_in_acc;
  logic [TW-1:0]      w_pp [NDIG];
  logic [CW-1:0]      w_sum;

  assign w_stall    = r_out_vld && !out_ready;
  // A new coefficient is only taken once nothing computed with the old one is still in flight.
  assign load_ready = (r_state != S_BUILD) && !r_s1_vld && !r_out_vld;
  assign w_load_acc = coef_load && load_ready;
  assign in_ready   = (r_state == S_READY) && !coef_load && !w_stall;
  assign w_in_acc   = in_valid && in_ready;
  assign out_valid  = r_out_vld;
  assign C          = r_c;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_load_acc) w_state_nxt = S_BUILD;
      S_BUILD: if (r_k == {DIGIT_W{1'b1}}) w_state_nxt = S_READY;
      S_READY: if (w_load_acc) w_state_nxt = S_BUILD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Each entry is the previous one plus A, so the table fills in DEPTH-1 cycles with only an adder.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_k <= '0;
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
    end else if (w_load_acc) begin
      r_a        <= coef_in;
      r_table[0] <= '0;
      r_k        <= DIGIT_W'(1);
    end else if (r_state == S_BUILD) begin
      r_table[r_k] <= r_table[r_k - 1'b1] + TW'(r_a);
      r_k          <= r_k + 1'b1;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NDIG; i++) begin
      w_pp[i] = r_table[X[i*DIGIT_W +: DIGIT_W]];
      w_sum   = w_sum + (CW'(r_pp[i]) << (i * DIGIT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_out_vld <= 1'b0;
      r_c       <= '0;
      for (int i = 0; i < NDIG; i++) r_pp[i] <= '0;
    end else if (!w_stall) begin
      r_s1_vld  <= w_in_acc;
      r_out_vld <= r_s1_vld;
      if (w_in_acc) begin
        for (int i = 0; i < NDIG; i++) r_pp[i] <= w_pp[i];
      end
      if (r_s1_vld) r_c <= w_sum;
    end
  end
endmodule

// File: tb/tb_lut_mult_pipe.sv
// Randomised and directed stimulus for lut_mult_pipe.
// Products come from plain X*A arithmetic, kept in a queue with the cycle each X was accepted.
module tb_lut_mult_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        coef_load;
  logic [7:0]  coef_in;
  logic        load_ready;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  X;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] C;

  lut_mult_pipe #(.BIT_WIDTH(8), .A_WIDTH(8), .DIGIT_W(4)) dut (
    .clk(clk), .rst(rst), .coef_load(coef_load), .coef_in(coef_in),
    .load_ready(load_ready), .in_valid(in_valid), .in_ready(in_ready), .X(X),
    .out_valid(out_valid), .out_ready(out_ready), .C(C)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int build_start = -1000;
  int model_a = 0;
  int exp_q[$];
  int acc_q[$];
  bit chk_lat = 1'b0;
  bit s_ld_acc, s_in_acc, s_out_hs, s_in_rdy;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called just after a falling edge with the inputs already driven; returns at the next falling edge.
  task automatic tick();
    int e, a;
    #1;
    s_ld_acc = coef_load && load_ready;
    s_in_rdy = in_ready;
    s_in_acc = in_valid && in_ready;
    s_out_hs = out_valid && out_ready;
    if (!rst && cyc > build_start && cyc <= build_start + 15)
      check_val("in_ready_during_build", int'(in_ready), 0);
    if (s_ld_acc) build_start = cyc;
    if (s_out_hs) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_out_valid", int'(out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check_val("C", int'(C), e);
        if (chk_lat) check_val("latency", cyc - a, 2);
      end
    end
    if (s_in_acc) begin
      exp_q.push_back(int'(X) * model_a);
      acc_q.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; coef_load = 1'b0; coef_in = '0; in_valid = 1'b0; X = '0; out_ready = 1'b1;
    tick();
    tick();
    exp_q.delete();
    acc_q.delete();
    build_start = -1000;
    check_val("rst_load_ready", int'(load_ready), 1);
    check_val("rst_in_ready", int'(in_ready), 0);
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_C", int'(C), 0);
    rst = 1'b0;
  endtask

  task automatic load(input int a);
    int n;
    coef_load = 1'b1;
    coef_in = 8'(a);
    tick();
    check_val("load_accepted", int'(s_ld_acc), 1);
    coef_load = 1'b0;
    model_a = a;
    n = 0;
    forever begin
      tick();
      if (s_in_rdy || n > 40) break;
      n++;
    end
    check_val("build_cycles", n, 15);
  endtask

  task automatic send(input int x);
    int n;
    in_valid = 1'b1;
    X = 8'(x);
    for (n = 0; n < 100; n++) begin
      tick();
      if (s_in_acc) break;
    end
    check_val("send_accepted", int'(n < 100), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() > 0; n++) tick();
    check_val("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1; coef_load = 1'b0; coef_in = '0; in_valid = 1'b0; X = '0; out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // Nothing may be accepted before a coefficient exists.
    in_valid = 1'b1; X = 8'd9;
    repeat (4) begin
      tick();
      check_val("idle_x_taken", int'(s_in_acc), 0);
    end
    in_valid = 1'b0;

    load(2);
    chk_lat = 1'b1;
    t0 = cyc;
    in_valid = 1'b1;
    for (int x = 0; x < 256; x++) begin
      X = 8'(x);
      for (int n = 0; n < 10; n++) begin
        tick();
        if (s_in_acc) break;
      end
    end
    in_valid = 1'b0;
    check_val("b2b_cycles", cyc - t0, 256);
    drain();

    load(255);
    send(255);
    send(1);
    drain();
    load(0);
    send(200);
    drain();
    chk_lat = 1'b0;

    // Backpressure: 70 must sit on C until released, then 77 and 84 follow.
    load(7);
    in_valid = 1'b1; X = 8'd10;
    tick();
    check_val("bp_acc10", int'(s_in_acc), 1);
    X = 8'd11;
    tick();
    check_val("bp_acc11", int'(s_in_acc), 1);
    out_ready = 1'b0; X = 8'd12;
    repeat (5) begin
      tick();
      check_val("bp_out_valid", int'(out_valid), 1);
      check_val("bp_C_held", int'(C), 70);
      check_val("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    send(12);
    drain();

    // A load request while a result waits must be ignored.
    out_ready = 1'b0;
    send(5);
    repeat (2) tick();
    coef_load = 1'b1; coef_in = 8'd9;
    repeat (3) begin
      tick();
      check_val("pend_load_ready", int'(load_ready), 0);
      check_val("pend_load_acc", int'(s_ld_acc), 0);
    end
    coef_load = 1'b0;
    out_ready = 1'b1;
    drain();
    send(6);
    drain();

    // Load and X together: load wins, X waits for the new table.
    coef_load = 1'b1; coef_in = 8'd11;
    in_valid = 1'b1; X = 8'd20;
    tick();
    check_val("sim_load_acc", int'(s_ld_acc), 1);
    check_val("sim_x_taken", int'(s_in_acc), 0);
    coef_load = 1'b0;
    model_a = 11;
    send(20);
    drain();

    // Reset in the sixth build cycle.
    coef_load = 1'b1; coef_in = 8'd5;
    tick();
    coef_load = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    build_start = -1000;
    check_val("midrst_in_ready", int'(in_ready), 0);
    check_val("midrst_out_valid", int'(out_valid), 0);
    check_val("midrst_load_ready", int'(load_ready), 1);
    in_valid = 1'b1; X = 8'd50;
    repeat (4) begin
      tick();
      check_val("midrst_x_taken", int'(s_in_acc), 0);
    end
    in_valid = 1'b0;
    load(3);
    send(100);
    drain();

    repeat (3) begin
      load($urandom_range(0, 255));
      repeat (300) begin
        in_valid  = 1'($urandom_range(0, 1));
        X         = 8'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
